// File: rtl/rca_acc_pkg.sv
// Shared types and helpers for the ripple-carry accumulator.
package rca_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must hold values 0..COUNT inclusive.
  function automatic int cnt_w(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// Combinational N-bit ripple-carry adder built from a chain of full adders.
module rca_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[N];

endmodule

// File: rtl/rca_accumulator.sv
// Sums COUNT operands per burst through an rca_nbit adder; result on a valid/ready port.
// Optional saturation on carry-out is enabled with `define RCA_ACC_SAT_EN.
module rca_accumulator
  import rca_acc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CW = cnt_w(COUNT);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_opnd, w_sum, w_acc_nxt;
  logic             w_cout;
  logic             w_in_xfer, w_out_xfer;
  logic [CW-1:0]    w_cnt_inc;

  assign w_opnd = ACC_W'(in_data);

  rca_nbit #(.N(ACC_W)) u_add (
    .a    (r_acc),
    .b    (w_opnd),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

`ifdef RCA_ACC_SAT_EN
  // Once saturated, any further nonzero operand carries out again, so it sticks.
  assign w_acc_nxt = w_cout ? {ACC_W{1'b1}} : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  assign in_ready   = (r_state != DONE);
  assign out_valid  = (r_state == DONE);
  assign out_sum    = r_acc;
  assign out_ovf    = r_ovf;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_cnt_inc  = r_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_xfer) w_state_nxt = (COUNT == 1) ? DONE : ACCUM;
      ACCUM:   if (w_in_xfer && (w_cnt_inc == CW'(COUNT))) w_state_nxt = DONE;
      DONE:    if (w_out_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_in_xfer) begin
          r_acc <= w_opnd;
          r_ovf <= 1'b0;
          r_cnt <= CW'(1);
        end
        ACCUM: if (w_in_xfer) begin
          r_acc <= w_acc_nxt;
          r_ovf <= r_ovf | w_cout;
          r_cnt <= w_cnt_inc;
        end
        // out_ovf is left alone so the flag survives until the next burst loads.
        DONE: if (w_out_xfer) begin
          r_acc <= '0;
          r_cnt <= '0;
        end
        default: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench: an 8-bit accumulator and a 5-bit one driven in lockstep from shared inputs.
module tb_rca_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_sum;
  logic       in_ready5, out_valid5, out_ovf5;
  logic [4:0] out_sum5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rca_accumulator #(.WIDTH(4), .ACC_W(8), .COUNT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  rca_accumulator #(.WIDTH(4), .ACC_W(5), .COUNT(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .in_data(in_data), .out_valid(out_valid5), .out_ready(out_ready),
    .out_sum(out_sum5), .out_ovf(out_ovf5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operand from a negedge and return just after the accepting posedge.
  task automatic send(input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] sum, input logic ovf);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   32'(out_sum),   32'(sum));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_ovf",   32'(out_ovf),   32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic burst: 3+5+7+9 = 0x18, valid one cycle after the 4th accept.
    send(4'd3); send(4'd5); send(4'd7);
    @(negedge clk);
    chk("b1_early_valid", 32'(out_valid), 32'd0);
    send(4'd9);
    chk_result("b1", 8'h18, 1'b0);
    chk("b1_in_ready", 32'(in_ready), 32'd0);
    pop();
    @(negedge clk);
    chk("b1_pop_valid", 32'(out_valid), 32'd0);
    chk("b1_pop_ready", 32'(in_ready), 32'd1);

    // Gapped 15s: 0x3C in 8 bits; in 5 bits 15,30,13(c),28 -> 28 with ovf.
    send(4'd15); idle(1); send(4'd15); idle(3); send(4'd15); send(4'd15); idle(2);
    chk_result("gap", 8'h3C, 1'b0);
`ifdef RCA_ACC_SAT_EN
    chk("ovf5_sum", 32'(out_sum5), 32'd31);
`else
    chk("ovf5_sum", 32'(out_sum5), 32'd28);
`endif
    chk("ovf5_ovf", 32'(out_ovf5), 32'd1);
    pop();
    @(negedge clk);
    chk("ovf5_sticky", 32'(out_ovf5), 32'd1);
    chk("ovf5_cleared_sum", 32'(out_sum5), 32'd0);

    // Backpressure: 2+4+6+8 = 0x14 held while an operand of 2 is offered.
    send(4'd2);
    @(negedge clk);
    chk("ovf5_reload", 32'(out_ovf5), 32'd0);
    send(4'd4); send(4'd6); send(4'd8);
    chk_result("bp", 8'h14, 1'b0);
    in_valid = 1'b1; in_data = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum_hold", 32'(out_sum),  32'h14);
      chk("bp_valid",    32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;

    // Back-to-back: next burst starts the cycle after the output transfer.
    pop();
    send(4'd1);
    send(4'd2); send(4'd3); send(4'd4);
    chk_result("b2b", 8'h0A, 1'b0);
    pop();

    // Reset mid-burst, then a fresh 1+1+1+1 burst.
    send(4'd7); send(4'd6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum",   32'(out_sum),   32'd0);
    chk("mid_rst_ovf",   32'(out_ovf),   32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk_result("post_rst", 8'h04, 1'b0);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
